// File: rtl/alu_sequencer_if.sv
// Bus between the sequencer and its neighbours: instruction fetch handshake
// toward the ROM and the registered operand/result path toward the ALU.
interface alu_sequencer_if #(parameter int PC_W = 8);
  logic            instr_req;
  logic [PC_W-1:0] instr_addr;
  logic            instr_valid;
  logic [8:0]      instr_data;
  logic [5:0]      alu_opcode;
  logic [7:0]      alu_in1;
  logic [7:0]      alu_in2;
  logic [7:0]      alu_result;
  logic            alu_overflow;

  modport master (
    output instr_req, instr_addr, alu_opcode, alu_in1, alu_in2,
    input  instr_valid, instr_data, alu_result, alu_overflow
  );

  modport slave (
    input  instr_req, instr_addr, alu_opcode, alu_in1, alu_in2,
    output instr_valid, instr_data, alu_result, alu_overflow
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/issue/writeback controller for the synchronous ALU;
// owns the PC, the 8x8 register file and the architectural overflow flag.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  alu_sequencer_if.master bus,
  output logic           flag,
  output logic           done,
  input  logic [2:0]     dbg_addr,
  output logic [7:0]     dbg_data
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALTED} state_t;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [8:0]      ir;
  logic [2:0]      dest;
  logic            wr_en;
  logic            fl_en;
  logic            req_q;
  logic [5:0]      opcode_q;
  logic [7:0]      in1_q;
  logic [7:0]      in2_q;
  logic [7:0]      regs [8];

  logic [2:0]      op;
  logic [2:0]      fa;
  logic [2:0]      fb;
  logic [PC_W-1:0] br_off;
  logic            br_taken;

  assign op       = ir[8:6];
  assign fa       = ir[5:3];
  assign fb       = ir[2:0];
  assign br_off   = {{(PC_W-3){ir[2]}}, ir[2:0]};
  assign br_taken = ((fa == 3'b000) && !flag) || ((fa == 3'b001) && flag);

  assign bus.instr_req  = req_q;
  assign bus.instr_addr = pc;
  assign bus.alu_opcode = opcode_q;
  assign bus.alu_in1    = in1_q;
  assign bus.alu_in2    = in2_q;
  assign dbg_data       = regs[dbg_addr];

  // Write/flag enables are resolved in DECODE so WB only needs the captured result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      ir       <= '0;
      dest     <= '0;
      wr_en    <= 1'b0;
      fl_en    <= 1'b0;
      req_q    <= 1'b0;
      opcode_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      flag     <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr_data;
            req_q <= 1'b0;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= FETCH;
          req_q <= 1'b1;
          pc    <= pc + PC_ONE;
          case (op)
            3'b000: regs[fa] <= regs[fb];
            3'b010, 3'b011, 3'b100, 3'b101: begin
              opcode_q <= {op, 3'b000};
              in1_q    <= regs[fa];
              in2_q    <= regs[fb];
              dest     <= fa;
              wr_en    <= (op == 3'b010) || (op == 3'b101);
              fl_en    <= (op != 3'b101);
              state    <= EXEC;
              req_q    <= 1'b0;
              pc       <= pc;
            end
            3'b110: begin
              if (fa == 3'b111) begin
                state <= HALTED;
                req_q <= 1'b0;
                done  <= 1'b1;
                pc    <= pc;
              end else if (fa != 3'b110) begin
                opcode_q <= {op, fa};
                in1_q    <= '0;
                in2_q    <= regs[fb];
                dest     <= fb;
                wr_en    <= fa inside {3'd0, 3'd1, 3'd2, 3'd5};
                fl_en    <= fa inside {3'd0, 3'd3, 3'd4};
                state    <= EXEC;
                req_q    <= 1'b0;
                pc       <= pc;
              end
            end
            3'b111: begin
              if (br_taken) pc <= pc + br_off;
            end
            default: ;
          endcase
        end
        EXEC: state <= WB;
        WB: begin
          if (wr_en) regs[dest] <= bus.alu_result;
          if (fl_en) flag <= bus.alu_overflow;
          pc    <= pc + PC_ONE;
          state <= FETCH;
          req_q <= 1'b1;
        end
        HALTED: begin
          if (start) begin
            pc    <= '0;
            state <= FETCH;
            req_q <= 1'b1;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: a ROM and registered ALU surround the sequencer, and an
// instruction-level model predicts PC, flag, registers and issued operands.
module tb_alu_sequencer;
  localparam int PC_W = 8;
  localparam logic [8:0] JUNK = 9'b110_111_000;
  localparam logic [2:0] OP_MOV = 3'd0, OP_NOP = 3'd1, OP_ADD = 3'd2, OP_MATCH = 3'd3,
                         OP_LT = 3'd4, OP_DIST = 3'd5, OP_A = 3'd6, OP_B = 3'd7;
  localparam logic [2:0] F_LSL = 3'd0, F_LSR = 3'd1, F_INCR = 3'd2, F_AND1 = 3'd3,
                         F_EQZ = 3'd4, F_ZERO = 3'd5, F_HALT = 3'd7;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, withhold = 1'b0;
  logic [2:0] dbg_addr = 3'd0;
  logic flag, done;
  logic [7:0] dbg_data;
  logic [8:0] rom [256];
  logic [7:0] alu_res_q = 8'd0;
  logic alu_ovf_q = 1'b0;
  int checks = 0, errors = 0;

  logic [PC_W-1:0] m_pc, last_fetch;
  logic m_flag, m_halted, m_idle;
  logic [7:0] m_regs [8];
  logic [5:0] m_op;
  logic [7:0] m_in1, m_in2;

  alu_sequencer_if #(.PC_W(PC_W)) bus ();

  alu_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .flag(flag), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Combinational ROM; a halt word sits on the data lines whenever valid is low.
  assign bus.instr_valid  = bus.instr_req & ~withhold;
  assign bus.instr_data   = bus.instr_valid ? rom[bus.instr_addr] : JUNK;
  assign bus.alu_result   = alu_res_q;
  assign bus.alu_overflow = alu_ovf_q;

  function automatic logic [8:0] alu_func(input logic [5:0] opc, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    case (opc)
      6'o20:   r = {1'b0, x} + {1'b0, y};
      6'o30:   r = {x == y, 8'h5A};
      6'o40:   r = {x < y, 8'h3C};
      6'o50:   r = {1'b0, (x > y) ? x - y : y - x};
      6'o60:   r = {y[7], y << 1};
      6'o61:   r = {y[0], y >> 1};
      6'o62:   r = {y == 8'hFF, y + 8'd1};
      6'o63:   r = {y[0], 8'hC3};
      6'o64:   r = {y == 8'd0, 8'hA5};
      6'o65:   r = 9'h000;
      default: r = 9'h1FF;
    endcase
    return r;
  endfunction

  // The team ALU registers its result one cycle after sampling the operands.
  always @(posedge clk) {alu_ovf_q, alu_res_q} <= alu_func(bus.alu_opcode, bus.alu_in1, bus.alu_in2);

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_flag = 1'b0; m_halted = 1'b0; m_idle = 1'b1;
    m_op = '0; m_in1 = '0; m_in2 = '0; last_fetch = '0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
  endtask

  // Whole-instruction effect, applied the moment the fetch handshake happens.
  task automatic model_exec(input logic [8:0] ins);
    logic [2:0] op, a, b;
    logic [8:0] r;
    int next_pc, off;
    op = ins[8:6]; a = ins[5:3]; b = ins[2:0];
    next_pc = int'(m_pc) + 1;
    if (op == OP_MOV) m_regs[a] = m_regs[b];
    else if (op >= OP_ADD && op <= OP_DIST) begin
      m_op = {op, 3'b000}; m_in1 = m_regs[a]; m_in2 = m_regs[b];
      r = alu_func(m_op, m_in1, m_in2);
      if (op == OP_ADD || op == OP_DIST) m_regs[a] = r[7:0];
      if (op != OP_DIST) m_flag = r[8];
    end else if (op == OP_A) begin
      if (a == F_HALT) begin
        m_halted = 1'b1;
        next_pc = int'(m_pc);
      end else if (a != 3'd6) begin
        m_op = {OP_A, a}; m_in1 = 8'd0; m_in2 = m_regs[b];
        r = alu_func(m_op, m_in1, m_in2);
        if (a == F_LSL || a == F_LSR || a == F_INCR || a == F_ZERO) m_regs[b] = r[7:0];
        if (a == F_LSL || a == F_AND1 || a == F_EQZ) m_flag = r[8];
      end
    end else if (op == OP_B) begin
      off = (b >= 3'd4) ? int'(b) - 8 : int'(b);
      if ((a == 3'd0 && !m_flag) || (a == 3'd1 && m_flag)) next_pc = int'(m_pc) + off;
    end
    if (next_pc < 0) next_pc += (1 << PC_W);
    next_pc = next_pc % (1 << PC_W);
    m_pc = next_pc[PC_W-1:0];
  endtask

  task automatic compare_cycle();
    if (reset) begin
      model_reset();
      return;
    end
    if (bus.instr_req) begin
      checkOutput("fetch_addr", bus.instr_addr, m_pc);
      checkOutput("fetch_flag", flag, m_flag);
      checkOutput("fetch_done", done, 0);
      checkOutput("fetch_reg", dbg_data, m_regs[dbg_addr]);
      checkOutput("alu_opcode", bus.alu_opcode, m_op);
      checkOutput("alu_in1", bus.alu_in1, m_in1);
      checkOutput("alu_in2", bus.alu_in2, m_in2);
      if (!withhold) begin
        last_fetch = bus.instr_addr;
        model_exec(rom[m_pc]);
      end
    end
    if (start && (m_idle || m_halted)) begin
      if (m_halted) m_pc = '0;
      m_idle = 1'b0;
      m_halted = 1'b0;
    end
  endtask

  task automatic tick();
    #1;
    compare_cycle();
    @(negedge clk);
  endtask

  task automatic check_reg(input string name, input logic [2:0] idx, input logic [7:0] expected);
    dbg_addr = idx;
    #1;
    checkOutput(name, dbg_data, expected);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = enc(OP_A, F_HALT, 3'd0);
  endtask

  task automatic run_program(input int stall, output int cycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 400) begin
      withhold = (cycles < stall);
      if (withhold) begin
        checkOutput("stall_req", bus.instr_req, 1);
        checkOutput("stall_addr", bus.instr_addr, 0);
      end
      dbg_addr = dbg_addr + 3'd1;
      tick();
      cycles++;
    end
    withhold = 1'b0;
    checkOutput("done_reached", done, 1);
  endtask

  task automatic applyStimulus();
    int cyc;
    clear_rom();
    reset = 1'b1;
    @(negedge clk);
    tick();
    checkOutput("rst_req", bus.instr_req, 0);
    checkOutput("rst_addr", bus.instr_addr, 0);
    checkOutput("rst_opcode", bus.alu_opcode, 0);
    checkOutput("rst_in1", bus.alu_in1, 0);
    checkOutput("rst_in2", bus.alu_in2, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_flag", flag, 0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ZERO/INCR/INCR/HALT: 4+4+4+2 cycles from start.
    rom[0] = enc(OP_A, F_ZERO, 3'd1); rom[1] = enc(OP_A, F_INCR, 3'd1);
    rom[2] = enc(OP_A, F_INCR, 3'd1); rom[3] = enc(OP_A, F_HALT, 3'd0);
    run_program(0, cyc);
    checkOutput("p1_cycles", cyc, 14);
    check_reg("p1_r1", 3'd1, 8'd2);
    checkOutput("p1_flag", flag, 0);
    checkOutput("p1_done", done, 1);
    @(negedge clk);

    // Build R1=200, R2=100 by shifts, then ADD wraps to 44 with carry.
    clear_rom();
    rom[0] = enc(OP_A, F_ZERO, 3'd1); rom[1] = enc(OP_A, F_INCR, 3'd1);
    rom[2] = enc(OP_A, F_LSL, 3'd1);  rom[3] = enc(OP_A, F_INCR, 3'd1);
    rom[4] = enc(OP_A, F_LSL, 3'd1);  rom[5] = enc(OP_A, F_LSL, 3'd1);
    rom[6] = enc(OP_A, F_LSL, 3'd1);  rom[7] = enc(OP_A, F_INCR, 3'd1);
    rom[8] = enc(OP_A, F_LSL, 3'd1);  rom[9] = enc(OP_A, F_LSL, 3'd1);
    rom[10] = enc(OP_MOV, 3'd2, 3'd1); rom[11] = enc(OP_A, F_LSL, 3'd1);
    rom[12] = enc(OP_ADD, 3'd1, 3'd2);
    run_program(0, cyc);
    check_reg("p2_r1", 3'd1, 8'd44);
    check_reg("p2_r2", 3'd2, 8'd100);
    checkOutput("p2_flag", flag, 1);
    @(negedge clk);

    clear_rom();
    rom[0] = enc(OP_A, F_ZERO, 3'd2); rom[1] = enc(OP_ADD, 3'd1, 3'd2);
    run_program(0, cyc);
    checkOutput("p3_cycles", cyc, 10);
    check_reg("p3_r1", 3'd1, 8'd44);
    checkOutput("p3_flag", flag, 0);
    @(negedge clk);

    // Taken BOF at pc=2 with offset -3 wraps to 255.
    clear_rom();
    rom[0] = enc(OP_A, F_EQZ, 3'd0); rom[1] = enc(OP_NOP, 3'd0, 3'd0);
    rom[2] = enc(OP_B, 3'd1, 3'b101);
    run_program(0, cyc);
    checkOutput("bof_cycles", cyc, 10);
    checkOutput("bof_target", last_fetch, 255);
    @(negedge clk);

    clear_rom();
    rom[0] = enc(OP_A, F_EQZ, 3'd0); rom[1] = enc(OP_NOP, 3'd0, 3'd0);
    rom[2] = enc(OP_B, 3'd0, 3'b101);
    run_program(0, cyc);
    checkOutput("bno_cycles", cyc, 10);
    checkOutput("bno_target", last_fetch, 3);
    @(negedge clk);

    // Five stalled FETCH cycles with a halt word on the undriven data lines.
    clear_rom();
    rom[0] = enc(OP_A, F_INCR, 3'd5);
    run_program(5, cyc);
    checkOutput("stall_cycles", cyc, 11);
    check_reg("stall_r5", 3'd5, 8'd1);
    @(negedge clk);

    clear_rom();
    rom[0] = enc(OP_A, F_INCR, 3'd4); rom[1] = enc(OP_A, F_LSL, 3'd4);
    rom[2] = enc(OP_A, F_LSL, 3'd4);  rom[3] = enc(OP_A, F_LSL, 3'd4);
    rom[4] = enc(OP_A, F_EQZ, 3'd0);  rom[5] = enc(OP_A, F_LSR, 3'd4);
    run_program(0, cyc);
    check_reg("lsr_r4", 3'd4, 8'd4);
    checkOutput("lsr_flag", flag, 1);
    @(negedge clk);

    clear_rom();
    rom[0] = enc(OP_MATCH, 3'd2, 3'd2); rom[1] = enc(OP_LT, 3'd0, 3'd0);
    rom[2] = enc(OP_A, F_EQZ, 3'd0);    rom[3] = enc(OP_DIST, 3'd1, 3'd4);
    run_program(0, cyc);
    check_reg("eqz_r0", 3'd0, 8'd0);
    check_reg("match_r2", 3'd2, 8'd0);
    check_reg("dist_r1", 3'd1, 8'd40);
    checkOutput("eqz_flag", flag, 1);
    @(negedge clk);

    clear_rom();
    rom[0] = enc(OP_A, F_ZERO, 3'd3);
    for (int i = 1; i <= 7; i++) rom[i] = enc(OP_A, F_INCR, 3'd3);
    run_program(0, cyc);
    check_reg("pre_r3", 3'd3, 8'd7);
    @(negedge clk);

    // Reset lands while INCR R3 sits in EXEC.
    clear_rom();
    rom[0] = enc(OP_NOP, 3'd0, 3'd0); rom[1] = enc(OP_A, F_INCR, 3'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checkOutput("exec_opcode", bus.alu_opcode, 6'o62);
    checkOutput("exec_in2", bus.alu_in2, 7);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_req", bus.instr_req, 0);
    checkOutput("mid_rst_addr", bus.instr_addr, 0);
    checkOutput("mid_rst_opcode", bus.alu_opcode, 0);
    checkOutput("mid_rst_in2", bus.alu_in2, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_flag", flag, 0);
    check_reg("mid_rst_r3", 3'd3, 8'd0);
    check_reg("mid_rst_r1", 3'd1, 8'd0);
    @(negedge clk);
    tick();
    tick();
    check_reg("post_rst_r3", 3'd3, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_program(0, cyc);
    checkOutput("post_rst_cycles", cyc, 8);
    check_reg("post_rst_r3b", 3'd3, 8'd1);
  endtask

  initial begin
    model_reset();
    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
